// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: opcode constants and hazard sequencer states.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } hz_state_t;

    // Opcodes whose rt field is a source operand (LW writes rt instead).
    function automatic logic reads_rt(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_SW) || (op == OP_BEQ);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with synchronous clear that wins over increment.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    logic [W-1:0] r_count;

    // Count events, stick at all-ones, clear on request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_count <= '0;
        else if (clr)
            r_count <= '0;
        else if (inc && (r_count != {W{1'b1}}))
            r_count <= r_count + 1'b1;
    end

    assign count = r_count;

endmodule

// File: rtl/hazard_unit.sv
// Load-use stall detector and taken-branch flush sequencer for the 5-stage core.
module hazard_unit
    import mips_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       id_opcode,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rt,
    input  logic             mem_branch,
    input  logic             mem_zero,
    input  logic             cnt_clr,
    output logic             hazard_detected,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_flush,
    output logic             pc_src,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    hz_state_t r_state;

    logic w_lu;
    logic w_tb;
    logic w_flush_act;
    logic w_stall_act;

    // Raw conditions; LW in ID writes rt, so only rs is compared for it.
    assign w_lu = ex_mem_read && (ex_rt != 5'd0) &&
                  ((ex_rt == id_rs) || ((ex_rt == id_rt) && reads_rt(id_opcode)));
    assign w_tb = mem_branch && mem_zero;

    // A branch in FLUSH is ignored; flush beats a simultaneous load-use.
    assign w_flush_act = w_tb && (r_state != FLUSH);
    assign w_stall_act = w_lu && (r_state == RUN) && !w_tb;

    // Sequencer: one bubble per load-use, one recovery cycle per redirect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RUN;
        end else begin
            case (r_state)
                RUN: begin
                    if (w_tb)
                        r_state <= FLUSH;
                    else if (w_lu)
                        r_state <= STALL;
                end
                STALL:   r_state <= w_tb ? FLUSH : RUN;
                FLUSH:   r_state <= RUN;
                default: r_state <= RUN;
            endcase
        end
    end

    // Outputs are combinational and forced quiet while reset is held.
    always_comb begin
        hazard_detected = 1'b0;
        pc_write        = 1'b0;
        if_id_write     = 1'b0;
        if_id_flush     = 1'b0;
        id_ex_flush     = 1'b0;
        ex_mem_flush    = 1'b0;
        pc_src          = 1'b0;
        if (rst_n) begin
            if (w_flush_act) begin
                pc_src       = 1'b1;
                if_id_flush  = 1'b1;
                id_ex_flush  = 1'b1;
                ex_mem_flush = 1'b1;
                pc_write     = 1'b1;
                if_id_write  = 1'b1;
            end else if (w_stall_act) begin
                hazard_detected = 1'b1;
            end else begin
                pc_write    = 1'b1;
                if_id_write = 1'b1;
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (hazard_detected),
        .clr   (cnt_clr),
        .count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (pc_src),
        .clr   (cnt_clr),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit with a cycle-level reference model.
// A narrow counter width lets saturation be reached in a few cycles.
module tb_hazard_unit;

    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [5:0]    id_opcode;
    logic [4:0]    id_rs, id_rt, ex_rt;
    logic          ex_mem_read, mem_branch, mem_zero, cnt_clr;
    logic          hazard_detected, pc_write, if_id_write;
    logic          if_id_flush, id_ex_flush, ex_mem_flush, pc_src;
    logic [CW-1:0] stall_cnt, flush_cnt;

    int n_vec = 0;
    int n_err = 0;

    // Model history: what happened in the previous cycle, plus counters.
    bit m_prev_stall, m_prev_flush;
    int m_stall, m_flush;
    bit e_hd, e_pcw, e_ifw, e_src;

    hazard_unit #(.CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt),
        .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
        .mem_branch(mem_branch), .mem_zero(mem_zero), .cnt_clr(cnt_clr),
        .hazard_detected(hazard_detected), .pc_write(pc_write),
        .if_id_write(if_id_write), .if_id_flush(if_id_flush),
        .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush),
        .pc_src(pc_src), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    // Compare every output against the model's expectation.
    task automatic chk_all(input string tag);
        chk({tag, ".hazard"}, int'(hazard_detected), int'(e_hd));
        chk({tag, ".pc_write"}, int'(pc_write), int'(e_pcw));
        chk({tag, ".if_id_write"}, int'(if_id_write), int'(e_ifw));
        chk({tag, ".pc_src"}, int'(pc_src), int'(e_src));
        chk({tag, ".if_id_flush"}, int'(if_id_flush), int'(e_src));
        chk({tag, ".id_ex_flush"}, int'(id_ex_flush), int'(e_src));
        chk({tag, ".ex_mem_flush"}, int'(ex_mem_flush), int'(e_src));
        chk({tag, ".stall_cnt"}, int'(stall_cnt), m_stall);
        chk({tag, ".flush_cnt"}, int'(flush_cnt), m_flush);
    endtask

    // Expected outputs from the specification rules and last-cycle history.
    task automatic model_eval();
        bit lu, tb;
        lu = ex_mem_read && (ex_rt != 0) &&
             ((ex_rt == id_rs) ||
              ((ex_rt == id_rt) && (id_opcode == 6'd0 || id_opcode == 6'd43 || id_opcode == 6'd4)));
        tb = mem_branch && mem_zero;
        e_hd = 0; e_pcw = 0; e_ifw = 0; e_src = 0;
        if (!rst_n) begin
            m_prev_stall = 0; m_prev_flush = 0; m_stall = 0; m_flush = 0;
        end else if (tb && !m_prev_flush) begin
            e_src = 1; e_pcw = 1; e_ifw = 1;
        end else if (lu && !m_prev_stall && !m_prev_flush) begin
            e_hd = 1;
        end else begin
            e_pcw = 1; e_ifw = 1;
        end
    endtask

    // One clock cycle: drive, check at negedge, advance the model at posedge.
    task automatic cyc(input bit r, input logic [5:0] op, input logic [4:0] rs,
                       input logic [4:0] rt, input bit mr, input logic [4:0] ert,
                       input bit br, input bit z, input bit clr);
        rst_n = r; id_opcode = op; id_rs = rs; id_rt = rt;
        ex_mem_read = mr; ex_rt = ert; mem_branch = br; mem_zero = z; cnt_clr = clr;
        #1;
        if (!r) begin
            // Reset must silence every output and counter without waiting for a clock.
            chk("rst_now.pc_write", int'(pc_write), 0);
            chk("rst_now.if_id_write", int'(if_id_write), 0);
            chk("rst_now.hazard", int'(hazard_detected), 0);
            chk("rst_now.pc_src", int'(pc_src), 0);
            chk("rst_now.stall_cnt", int'(stall_cnt), 0);
        end
        @(negedge clk);
        model_eval();
        chk_all("cyc");
        @(posedge clk);
        if (rst_n) begin
            m_prev_stall = e_hd;
            m_prev_flush = e_src;
            if (clr) begin
                m_stall = 0; m_flush = 0;
            end else begin
                if (e_hd && m_stall < CMAX) m_stall++;
                if (e_src && m_flush < CMAX) m_flush++;
            end
        end
        #1;
    endtask

    task automatic nop();
        cyc(1, 6'd0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0);
    endtask

    // ADD $x,$2,$3 in ID with LW $2 in EX: classic load-use.
    task automatic lu_add();
        cyc(1, 6'd0, 5'd2, 5'd3, 1, 5'd2, 0, 0, 0);
    endtask

    logic [5:0] ops [4] = '{6'd0, 6'd43, 6'd4, 6'd8};

    initial begin
        rst_n = 0; id_opcode = 0; id_rs = 0; id_rt = 0;
        ex_mem_read = 0; ex_rt = 0; mem_branch = 0; mem_zero = 0; cnt_clr = 0;
        m_prev_stall = 0; m_prev_flush = 0; m_stall = 0; m_flush = 0;
        cyc(0, 6'd0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0);
        cyc(0, 6'd0, 5'd2, 5'd3, 1, 5'd2, 1, 1, 0);
        chk("reset.stall_cnt", int'(stall_cnt), 0);
        chk("reset.flush_cnt", int'(flush_cnt), 0);
        nop();
        chk("run.pc_write", int'(pc_write), 1);

        // Load-use on rs: exactly one bubble.
        lu_add();
        chk("lu.stall_cnt", int'(stall_cnt), 1);
        cyc(1, 6'd0, 5'd2, 5'd3, 0, 5'd0, 0, 0, 0);
        chk("lu_after.stall_cnt", int'(stall_cnt), 1);

        // No stall: $zero destination, and LW in ID matching only on rt.
        cyc(1, 6'd0, 5'd0, 5'd3, 1, 5'd0, 0, 0, 0);
        cyc(1, 6'd35, 5'd5, 5'd2, 1, 5'd2, 0, 0, 0);
        chk("nolu.stall_cnt", int'(stall_cnt), 1);

        // rt match per opcode: R-type, SW, BEQ stall; ADDI does not.
        foreach (ops[k]) begin
            cyc(1, ops[k], 5'd9, 5'd7, 1, 5'd7, 0, 0, 0);
            nop();
        end
        chk("rtmatch.stall_cnt", int'(stall_cnt), 4);

        // Taken branch with simultaneous load-use: flush wins, then masked cycle.
        cyc(1, 6'd0, 5'd2, 5'd3, 1, 5'd2, 1, 1, 0);
        chk("tb.flush_cnt", int'(flush_cnt), 1);
        cyc(1, 6'd0, 5'd2, 5'd3, 1, 5'd2, 1, 1, 0);
        chk("tb_after.flush_cnt", int'(flush_cnt), 1);
        chk("tb_after.stall_cnt", int'(stall_cnt), 4);
        // Branch not taken does nothing.
        cyc(1, 6'd0, 5'd0, 5'd0, 0, 5'd0, 1, 0, 0);
        // Branch resolving while in STALL redirects.
        lu_add();
        cyc(1, 6'd0, 5'd2, 5'd3, 1, 5'd2, 1, 1, 0);
        chk("stall_tb.flush_cnt", int'(flush_cnt), 2);
        nop();

        // Held load-use: stall, masked, stall.
        lu_add(); lu_add(); lu_add();
        chk("held.stall_cnt", int'(stall_cnt), 7);
        nop();

        // Saturation: clear, climb to max-1, two more stalls, stays at max.
        cyc(1, 6'd0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 1);
        chk("clr.stall_cnt", int'(stall_cnt), 0);
        chk("clr.flush_cnt", int'(flush_cnt), 0);
        for (int i = 0; i < CMAX - 1; i++) begin
            lu_add(); nop();
        end
        chk("pre.stall_cnt", int'(stall_cnt), CMAX - 1);
        lu_add(); nop(); lu_add(); nop();
        chk("sat.stall_cnt", int'(stall_cnt), CMAX);
        cyc(1, 6'd0, 5'd2, 5'd3, 1, 5'd2, 0, 0, 1);
        chk("clr_prio.stall_cnt", int'(stall_cnt), 0);
        nop();

        // Reset in the middle of STALL, then a normal stall after release.
        lu_add();
        cyc(0, 6'd0, 5'd2, 5'd3, 1, 5'd2, 0, 0, 0);
        lu_add();
        chk("post_rst.stall_cnt", int'(stall_cnt), 1);
        nop();

        // Reset in the middle of FLUSH.
        cyc(1, 6'd0, 5'd0, 5'd0, 0, 5'd0, 1, 1, 0);
        cyc(0, 6'd0, 5'd0, 5'd0, 0, 5'd0, 1, 1, 0);
        cyc(1, 6'd0, 5'd0, 5'd0, 0, 5'd0, 1, 1, 0);
        chk("post_rst_tb.flush_cnt", int'(flush_cnt), 1);
        nop();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
